tailors_row_sched: RTL and testbench

Row scheduler for the tailors operand buffer pair in the sparse-multiply datapath. It accepts one row descriptor per row (base address and length for the A fiber and the B fiber). For each row it clears the buffer, sequences reads from the A and B operand memories, and forwards the returned words to the buffer inputs. It also flags rows that overbook the buffer, i.e. rows longer than BUFFER_SIZE.

---
 rtl/tailors_row_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_tailors_row_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tailors_row_sched.sv
// tailors_row_sched -- row scheduler for the tailors operand buffer pair.
//
// For each accepted row descriptor the scheduler pulses a buffer clear,
// walks the A and B fibers (one read per fiber per unstalled cycle),
// forwards the returned words to the buffer, and raises row_done_o when
// the last read data has landed. Rows longer than BUFFER_SIZE are flagged
// on overbook_a_o / overbook_b_o but still fully issued.
//
// Optional build macro: TAILORS_SCHED_PERF_EN
//   adds row_count_o / overbook_count_o (16-bit saturating counters).
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   desc_valid_i / desc_ready_o  row descriptor handshake
//   desc_{a,b}_base_i/_len_i     fiber start address and element count
//   stall_i                      freeze read issue (FETCH only)
//   {a,b}_rd_en_o/_addr_o        operand memory read request
//   {a,b}_rd_data_i              read data, one cycle after the strobe
//   buf_new_row_o                buffer clear pulse
//   buf_{a,b}_input_o/_valid_o   word to the buffer
//   overbook_{a,b}_o             current row fiber longer than BUFFER_SIZE
//   row_done_o                   end-of-row pulse
//   busy_o                       scheduler not idle

// Per-fiber issue lane: latched base/length, issue counter, address
// generation and the one-cycle data-valid alignment.
module tailors_row_lane #(
    parameter int BUFFER_SIZE = 4,
    parameter int WORD_SIZE   = 4,
    parameter int ADDR_W      = 8,
    parameter int LEN_W       = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [ADDR_W-1:0]    base_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic                 issue_ok_i,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [WORD_SIZE-1:0] rd_data_i,
    output logic [WORD_SIZE-1:0] buf_input_o,
    output logic                 buf_valid_o,
    output logic                 ob_now_o,
    output logic                 len_zero_o,
    output logic                 last_o
);
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              valid_q;

    assign rd_en_o     = issue_ok_i && (cnt_q < len_q);
    // Address wraps naturally at 2^ADDR_W.
    assign rd_addr_o   = rd_en_o ? (base_q + ADDR_W'(cnt_q)) : '0;
    assign buf_valid_o = valid_q;
    assign buf_input_o = valid_q ? rd_data_i : '0;
    assign ob_now_o    = len_q > LEN_W'(BUFFER_SIZE);
    assign len_zero_o  = (len_q == '0);

    always_comb begin
        cnt_d  = cnt_q + (rd_en_o ? LEN_W'(1) : '0);
        // True when this cycle's issue (if any) completes the fiber.
        last_o = (cnt_d == len_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en_o;
            if (load_i) begin
                base_q <= base_i;
                len_q  <= len_i;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_d;
            end
        end
    end
endmodule

module tailors_row_sched #(
    parameter int BUFFER_SIZE = 4,
    parameter int WORD_SIZE   = 4,
    parameter int ADDR_W      = 8,
    parameter int LEN_W       = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    input  logic [ADDR_W-1:0]    desc_a_base_i,
    input  logic [LEN_W-1:0]     desc_a_len_i,
    input  logic [ADDR_W-1:0]    desc_b_base_i,
    input  logic [LEN_W-1:0]     desc_b_len_i,
    input  logic                 stall_i,
    output logic                 a_rd_en_o,
    output logic [ADDR_W-1:0]    a_rd_addr_o,
    input  logic [WORD_SIZE-1:0] a_rd_data_i,
    output logic                 b_rd_en_o,
    output logic [ADDR_W-1:0]    b_rd_addr_o,
    input  logic [WORD_SIZE-1:0] b_rd_data_i,
    output logic                 buf_new_row_o,
    output logic [WORD_SIZE-1:0] buf_a_input_o,
    output logic                 buf_a_valid_o,
    output logic [WORD_SIZE-1:0] buf_b_input_o,
    output logic                 buf_b_valid_o,
    output logic                 overbook_a_o,
    output logic                 overbook_b_o,
    output logic                 row_done_o,
`ifdef TAILORS_SCHED_PERF_EN
    output logic [15:0]          row_count_o,
    output logic [15:0]          overbook_count_o,
`endif
    output logic                 busy_o
);
    localparam int NUM_LANES = 2;  // lane 0 = A fiber, lane 1 = B fiber

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                                 load, issue_ok;
    logic [NUM_LANES-1:0][ADDR_W-1:0]     base, rd_addr;
    logic [NUM_LANES-1:0][LEN_W-1:0]      len;
    logic [NUM_LANES-1:0][WORD_SIZE-1:0]  rd_data, buf_input;
    logic [NUM_LANES-1:0]                 rd_en, buf_valid, ob_now, len_zero, last;
    logic [NUM_LANES-1:0]                 overbook_q;

    assign base    = {desc_b_base_i, desc_a_base_i};
    assign len     = {desc_b_len_i, desc_a_len_i};
    assign rd_data = {b_rd_data_i, a_rd_data_i};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        tailors_row_lane #(
            .BUFFER_SIZE(BUFFER_SIZE), .WORD_SIZE(WORD_SIZE),
            .ADDR_W(ADDR_W), .LEN_W(LEN_W)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .load_i      (load),
            .base_i      (base[g]),
            .len_i       (len[g]),
            .issue_ok_i  (issue_ok),
            .rd_en_o     (rd_en[g]),
            .rd_addr_o   (rd_addr[g]),
            .rd_data_i   (rd_data[g]),
            .buf_input_o (buf_input[g]),
            .buf_valid_o (buf_valid[g]),
            .ob_now_o    (ob_now[g]),
            .len_zero_o  (len_zero[g]),
            .last_o      (last[g])
        );
    end

    assign a_rd_en_o     = rd_en[0];
    assign a_rd_addr_o   = rd_addr[0];
    assign b_rd_en_o     = rd_en[1];
    assign b_rd_addr_o   = rd_addr[1];
    assign buf_a_input_o = buf_input[0];
    assign buf_a_valid_o = buf_valid[0];
    assign buf_b_input_o = buf_input[1];
    assign buf_b_valid_o = buf_valid[1];
    assign overbook_a_o  = overbook_q[0];
    assign overbook_b_o  = overbook_q[1];

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (desc_valid_i) state_d = S_CLEAR;
            S_CLEAR: state_d = (&len_zero) ? S_DRAIN : S_FETCH;
            // Leave once the final issue happens; lanes that were already
            // complete report last_o continuously.
            S_FETCH: if (&last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        desc_ready_o  = (state_q == S_IDLE);
        load          = (state_q == S_IDLE) && desc_valid_i;
        buf_new_row_o = (state_q == S_CLEAR);
        issue_ok      = (state_q == S_FETCH) && !stall_i;
        row_done_o    = (state_q == S_DONE);
        busy_o        = (state_q != S_IDLE);
    end

    // Overbook flags sampled in CLEAR, held for the rest of the row.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                   overbook_q <= '0;
        else if (state_q == S_CLEAR) overbook_q <= ob_now;
    end

`ifdef TAILORS_SCHED_PERF_EN
    logic [15:0] row_cnt_q, ob_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_cnt_q <= '0;
            ob_cnt_q  <= '0;
        end else begin
            if (state_q == S_DONE && row_cnt_q != 16'hFFFF)
                row_cnt_q <= row_cnt_q + 16'd1;
            if (state_q == S_CLEAR && (|ob_now) && ob_cnt_q != 16'hFFFF)
                ob_cnt_q <= ob_cnt_q + 16'd1;
        end
    end

    assign row_count_o      = row_cnt_q;
    assign overbook_count_o = ob_cnt_q;
`endif
endmodule

// File: tb/tb_tailors_row_sched.sv
module tb_tailors_row_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       desc_valid, desc_ready;
    logic [7:0] a_base, a_len, b_base, b_len;
    logic       stall;
    logic       a_rd_en, b_rd_en;
    logic [7:0] a_rd_addr, b_rd_addr;
    logic [3:0] a_rd_data, b_rd_data;
    logic       new_row, a_valid, b_valid, ob_a, ob_b, row_done, busy;
    logic [3:0] a_in, b_in;
`ifdef TAILORS_SCHED_PERF_EN
    logic [15:0] row_count, ob_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic prev_ob_a, prev_ob_b;

    always #5 clk = ~clk;

    tailors_row_sched dut (
        .clk_i(clk), .rst_i(rst),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .desc_a_base_i(a_base), .desc_a_len_i(a_len),
        .desc_b_base_i(b_base), .desc_b_len_i(b_len),
        .stall_i(stall),
        .a_rd_en_o(a_rd_en), .a_rd_addr_o(a_rd_addr), .a_rd_data_i(a_rd_data),
        .b_rd_en_o(b_rd_en), .b_rd_addr_o(b_rd_addr), .b_rd_data_i(b_rd_data),
        .buf_new_row_o(new_row),
        .buf_a_input_o(a_in), .buf_a_valid_o(a_valid),
        .buf_b_input_o(b_in), .buf_b_valid_o(b_valid),
        .overbook_a_o(ob_a), .overbook_b_o(ob_b),
        .row_done_o(row_done),
`ifdef TAILORS_SCHED_PERF_EN
        .row_count_o(row_count), .overbook_count_o(ob_count),
`endif
        .busy_o(busy)
    );

    // Memory contents as a function of address.
    function automatic logic [3:0] memf(input logic [7:0] a);
        return a[3:0] ^ a[7:4] ^ 4'h9;
    endfunction

    // One-cycle-latency memories; junk when not read.
    logic       a_pend, b_pend;
    logic [7:0] a_pend_addr, b_pend_addr;
    always @(negedge clk) begin
        a_pend = a_rd_en; a_pend_addr = a_rd_addr;
        b_pend = b_rd_en; b_pend_addr = b_rd_addr;
    end
    always @(posedge clk) begin
        a_rd_data <= a_pend ? memf(a_pend_addr) : 4'($urandom);
        b_rd_data <= b_pend ? memf(b_pend_addr) : 4'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one row from handshake (offset 0) to desc_ready return and check
    // every cycle against a schedule derived from the row rules.
    task automatic run_row(input logic [7:0] ab, input logic [7:0] al,
                           input logic [7:0] bb, input logic [7:0] bl,
                           input bit [127:0] sm, input bit junk);
        logic       ea_en [0:127];
        logic       eb_en [0:127];
        logic [7:0] ea_ad [0:127];
        logic [7:0] eb_ad [0:127];
        int na = 0, nb = 0, k = 2, done_k;
        logic ob_ea, ob_eb;
        for (int i = 0; i < 128; i++) begin
            ea_en[i] = 0; eb_en[i] = 0; ea_ad[i] = 0; eb_ad[i] = 0;
        end
        if (al == 0 && bl == 0) done_k = 3;
        else begin
            while (na < al || nb < bl) begin
                if (!sm[k]) begin
                    if (na < al) begin ea_en[k] = 1; ea_ad[k] = ab + 8'(na); na++; end
                    if (nb < bl) begin eb_en[k] = 1; eb_ad[k] = bb + 8'(nb); nb++; end
                end
                k++;
            end
            done_k = k + 1;  // last fetch at k-1, drain at k
        end
        ob_ea = (al > 4);
        ob_eb = (bl > 4);
        for (int off = 0; off <= done_k + 1; off++) begin
            if (off == 0) begin
                desc_valid = 1; a_base = ab; a_len = al; b_base = bb; b_len = bl;
            end else if (off <= done_k) begin
                // Upstream noise while busy must be ignored.
                desc_valid = junk ? 1'($urandom) : 1'b0;
                if (junk) begin
                    a_base = 8'($urandom); a_len = 8'($urandom);
                    b_base = 8'($urandom); b_len = 8'($urandom);
                end
            end else desc_valid = 0;
            stall = sm[off];
            #3;
            chk("a_rd_en", a_rd_en, ea_en[off]);
            chk("b_rd_en", b_rd_en, eb_en[off]);
            if (ea_en[off]) chk("a_rd_addr", a_rd_addr, ea_ad[off]);
            if (eb_en[off]) chk("b_rd_addr", b_rd_addr, eb_ad[off]);
            chk("buf_a_valid", a_valid, off > 0 ? ea_en[off-1] : 1'b0);
            chk("buf_b_valid", b_valid, off > 0 ? eb_en[off-1] : 1'b0);
            if (off > 0 && ea_en[off-1]) chk("buf_a_input", a_in, memf(ea_ad[off-1]));
            if (off > 0 && eb_en[off-1]) chk("buf_b_input", b_in, memf(eb_ad[off-1]));
            chk("buf_new_row", new_row, off == 1);
            chk("row_done", row_done, off == done_k);
            chk("desc_ready", desc_ready, off == 0 || off == done_k + 1);
            chk("busy", busy, off >= 1 && off <= done_k);
            chk("overbook_a", ob_a, off >= 2 ? ob_ea : prev_ob_a);
            chk("overbook_b", ob_b, off >= 2 ? ob_eb : prev_ob_b);
            @(posedge clk); #1;
        end
        prev_ob_a = ob_ea;
        prev_ob_b = ob_eb;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, desc_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rd_en"}, {a_rd_en, b_rd_en}, 2'b00);
        chk({tag, "_valid"}, {a_valid, b_valid}, 2'b00);
        chk({tag, "_new_row"}, new_row, 1'b0);
        chk({tag, "_row_done"}, row_done, 1'b0);
        chk({tag, "_overbook"}, {ob_a, ob_b}, 2'b00);
    endtask

    initial begin
        bit [127:0] sm;
        rst = 1; desc_valid = 0; stall = 0;
        a_base = 0; a_len = 0; b_base = 0; b_len = 0;
        prev_ob_a = 0; prev_ob_b = 0;
        #2;
        chk_idle("reset");
`ifdef TAILORS_SCHED_PERF_EN
        chk("reset_row_count", row_count, 0);
        chk("reset_ob_count", ob_count, 0);
`endif
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        // Basic row, zero-length row, overbook, stall window, address wrap.
        run_row(8'h10, 3, 8'h20, 2, '0, 0);
        run_row(8'h40, 6, 8'h80, 1, '0, 0);
        run_row(8'h33, 0, 8'h44, 0, '0, 0);
        sm = '0; sm[3] = 1; sm[4] = 1;
        run_row(8'h50, 4, 8'h60, 0, sm, 0);
        run_row(8'hFE, 3, 8'hFD, 5, '0, 1);

        // Reset in the middle of FETCH of an overbooked row.
        desc_valid = 1; a_base = 8'h70; a_len = 6; b_base = 8'h90; b_len = 5;
        @(posedge clk); #1 desc_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_ob", {ob_a, ob_b}, 2'b11);
        #1 rst = 1;
        #1;
        chk_idle("midrst");
        @(posedge clk); #1 rst = 0;
        #3;
        chk_idle("post_rst");
        @(posedge clk); #1;
        prev_ob_a = 0; prev_ob_b = 0;

        // Three rows after reset, one of them overbooked.
        run_row(8'h01, 2, 8'h02, 2, '0, 0);
        run_row(8'h03, 5, 8'h04, 1, '0, 0);
        run_row(8'h05, 1, 8'h06, 0, '0, 0);
`ifdef TAILORS_SCHED_PERF_EN
        #3;
        chk("row_count", row_count, 3);
        chk("overbook_count", ob_count, 1);
        @(posedge clk); #1;
`endif

        // Random rows with random stall (including outside FETCH).
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 128; i++) sm[i] = ($urandom_range(3) == 0);
            run_row(8'($urandom), 8'($urandom_range(9)), 8'($urandom),
                    8'($urandom_range(9)), sm, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
